// File: rtl/mmio_pkt_mailbox.sv
// mmio_pkt_mailbox
//   Memory-mapped packet mailbox. The CPU reaches an 8-word register window.
//   The window holds STATUS, CONTROL, TX_DATA, RX_DATA, RX_POP and CLEAR.
//   A TX FIFO carries words from the CPU to the network, and an RX FIFO
//   carries flits from the network to the CPU. The read port is registered,
//   and a level interrupt flags pending RX data or an RX overflow.
//
// Ports
//   clock, reset          rising-edge clock, async active-low reset
//   addr_in/data_in/wb_in CPU word address, write data, byte strobes
//   data_out              registered read data (1-cycle latency)
//   tx_data/tx_valid      TX FIFO head toward the network; tx_ready accepts it
//   rx_data/rx_valid      incoming flit, no backpressure
//   irq                   irq_en & (rx_nonempty | rx_overflow)

// Simple circular FIFO. Storage is not reset; only pointers and count are.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module mmio_pkt_fifo #(
   parameter int W = 32,
   parameter int D = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           wdata,
   output logic [W-1:0]           head,
   output logic [$clog2(D):0]     count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(D);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [D];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          pop_eff, push_eff;

   assign empty    = (count == '0);
   assign full     = (count == CW'(D));
   assign pop_eff  = pop & ~empty;
   assign push_eff = push & (~full | pop_eff);
   assign head     = mem[rd_ptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_eff) wr_ptr <= wr_ptr + AW'(1);
         if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push_eff) - CW'(pop_eff);
      end
   end

   always_ff @(posedge clock) begin
      if (push_eff) mem[wr_ptr] <= wdata;
   end
endmodule

module mmio_pkt_mailbox #(
   parameter int MEMORY_BUS_WIDTH = 32,
   parameter int FIFO_DEPTH       = 8,
   parameter int BASE_WORD        = 0
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [MEMORY_BUS_WIDTH-3:0] addr_in,
   input  logic [MEMORY_BUS_WIDTH-1:0] data_in,
   input  logic [3:0]                  wb_in,
   output logic [MEMORY_BUS_WIDTH-1:0] data_out,
   output logic [MEMORY_BUS_WIDTH-1:0] tx_data,
   output logic                        tx_valid,
   input  logic                        tx_ready,
   input  logic [MEMORY_BUS_WIDTH-1:0] rx_data,
   input  logic                        rx_valid,
   output logic                        irq
);
   localparam int W  = MEMORY_BUS_WIDTH;
   localparam int AW = W - 2;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [AW-4:0] BLK = (AW-3)'(BASE_WORD >> 3);

   localparam logic [2:0] OFF_STATUS  = 3'd0;
   localparam logic [2:0] OFF_CONTROL = 3'd1;
   localparam logic [2:0] OFF_TX_DATA = 3'd2;
   localparam logic [2:0] OFF_RX_DATA = 3'd3;
   localparam logic [2:0] OFF_RX_POP  = 3'd4;
   localparam logic [2:0] OFF_CLEAR   = 3'd5;

   // decode
   logic       hit, wr;
   logic [2:0] off;

   assign hit = (addr_in[AW-1:3] == BLK);
   assign off = addr_in[2:0];
   assign wr  = hit & (|wb_in);

   // state
   logic irq_en, tx_enable, rx_ovf, tx_drop;

   // fifo hookup
   logic [W-1:0]  tx_head, rx_head;
   logic [CW-1:0] tx_count, rx_count;
   logic          tx_full, tx_empty, rx_full, rx_empty;
   logic          tx_push, tx_pop, rx_pop_req, clr;
   logic          tx_drop_set, rx_ovf_set;

   assign tx_push    = wr & (off == OFF_TX_DATA);
   assign rx_pop_req = wr & (off == OFF_RX_POP);
   assign clr        = wr & (off == OFF_CLEAR);
   assign tx_pop     = tx_valid & tx_ready;

   // A full FIFO is never empty, so the raw pop request is enough here.
   assign tx_drop_set = tx_push  & tx_full & ~tx_pop;
   assign rx_ovf_set  = rx_valid & rx_full & ~rx_pop_req;

   mmio_pkt_fifo #(.W(W), .D(FIFO_DEPTH)) u_tx_fifo (
      .clock (clock),
      .reset (reset),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata (data_in),
      .head  (tx_head),
      .count (tx_count),
      .full  (tx_full),
      .empty (tx_empty)
   );

   mmio_pkt_fifo #(.W(W), .D(FIFO_DEPTH)) u_rx_fifo (
      .clock (clock),
      .reset (reset),
      .push  (rx_valid),
      .pop   (rx_pop_req),
      .wdata (rx_data),
      .head  (rx_head),
      .count (rx_count),
      .full  (rx_full),
      .empty (rx_empty)
   );

   // control and sticky bits; a set in the same cycle as a clear wins
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         irq_en    <= 1'b0;
         tx_enable <= 1'b0;
         rx_ovf    <= 1'b0;
         tx_drop   <= 1'b0;
      end else begin
         if (wr && off == OFF_CONTROL && wb_in[0]) begin
            irq_en    <= data_in[0];
            tx_enable <= data_in[1];
         end
         if (rx_ovf_set)             rx_ovf  <= 1'b1;
         else if (clr && data_in[2]) rx_ovf  <= 1'b0;
         if (tx_drop_set)            tx_drop <= 1'b1;
         else if (clr && data_in[3]) tx_drop <= 1'b0;
      end
   end

   // read mux sees pre-edge state, so RX_DATA returns the old head on a pop
   logic [W-1:0] rd_data;

   always_comb begin
      rd_data = '0;
      if (hit) begin
         case (off)
            OFF_STATUS: begin
               rd_data[0]     = ~rx_empty;
               rd_data[1]     = tx_full;
               rd_data[2]     = rx_ovf;
               rd_data[3]     = tx_drop;
               rd_data[15:8]  = 8'(rx_count);
               rd_data[23:16] = 8'(tx_count);
            end
            OFF_CONTROL: rd_data[1:0] = {tx_enable, irq_en};
            OFF_RX_DATA: rd_data      = rx_empty ? '0 : rx_head;
            default:     rd_data      = '0;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) data_out <= '0;
      else        data_out <= rd_data;
   end

   // network side and interrupt, decoded from registered state
   assign tx_valid = tx_enable & ~tx_empty;
   assign tx_data  = tx_empty ? '0 : tx_head;
   assign irq      = irq_en & (~rx_empty | rx_ovf);
endmodule

// File: tb/tb_mmio_pkt_mailbox.sv
module tb_mmio_pkt_mailbox;
   localparam int W    = 32;
   localparam int BASE = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic [W-3:0]  addr_in;
   logic [W-1:0]  data_in;
   logic [3:0]    wb_in;
   logic [W-1:0]  data_out;
   logic [W-1:0]  tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [W-1:0]  rx_data;
   logic          rx_valid;
   logic          irq;

   int checks   = 0;
   int failures = 0;

   logic [31:0] txq[$];
   logic [31:0] rxq[$];

   mmio_pkt_mailbox #(.MEMORY_BUS_WIDTH(W), .FIFO_DEPTH(8), .BASE_WORD(BASE)) dut (
      .clock    (clock),
      .reset    (reset),
      .addr_in  (addr_in),
      .data_in  (data_in),
      .wb_in    (wb_in),
      .data_out (data_out),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .irq      (irq)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr_raw(input logic [W-3:0] a, input logic [31:0] d, input logic [3:0] s);
      addr_in = a; data_in = d; wb_in = s;
      tick();
      wb_in = 4'h0;
   endtask

   task automatic rd_raw(input logic [W-3:0] a, output logic [31:0] v);
      addr_in = a; wb_in = 4'h0;
      tick();
      v = data_out;
   endtask

   task automatic wr(input int off, input logic [31:0] d);
      wr_raw((W-2)'(BASE + off), d, 4'hF);
   endtask

   task automatic rd(input int off, output logic [31:0] v);
      rd_raw((W-2)'(BASE + off), v);
   endtask

   task automatic tx_push(input logic [31:0] d);
      wr(2, d);
      if (txq.size() < 8) txq.push_back(d);
   endtask

   task automatic rx_flit(input logic [31:0] d);
      rx_valid = 1'b1; rx_data = d;
      tick();
      rx_valid = 1'b0;
      if (rxq.size() < 8) rxq.push_back(d);
   endtask

   // drain the TX scoreboard with tx_ready held high: one flit every cycle
   task automatic drain_tx(input string name);
      logic [31:0] e;
      tx_ready = 1'b1;
      for (int i = 0; i < 12 && txq.size() > 0; i++) begin
         e = txq.pop_front();
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== e) begin
            failures++;
            $display("FAIL %s: valid=%b data=%h expected valid=1 data=%h", name, tx_valid, tx_data, e);
         end
         tick();
      end
      tx_ready = 1'b0;
      checks++;
      if (tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s_end: tx_valid=%b expected 0", name, tx_valid);
      end
   endtask

   task automatic test_reset();
      logic [31:0] v;
      reset = 1'b0; addr_in = '0; data_in = '0; wb_in = '0;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
      repeat (2) tick();
      checks++;
      if (tx_valid !== 1'b0 || tx_data !== 32'h0 || irq !== 1'b0 || data_out !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs: valid=%b data=%h irq=%b dout=%h expected all 0", tx_valid, tx_data, irq, data_out);
      end
      reset = 1'b1;
      tick();
      for (int o = 0; o < 8; o++) begin
         rd(o, v);
         checks++;
         if (v !== 32'h0) begin
            failures++;
            $display("FAIL reset_read_off%0d: got %h expected 0", o, v);
         end
      end
   endtask

   task automatic test_decode();
      logic [31:0] v;
      wr_raw((W-2)'(BASE + 8 + 1), 32'h3, 4'hF);  // outside the window
      rd(1, v);
      checks++;
      if (v !== 32'h0) begin failures++; $display("FAIL miss_write: got %h expected 0", v); end
      wr_raw((W-2)'(BASE + 1), 32'h3, 4'b0010);   // strobe 0 clear
      rd(1, v);
      checks++;
      if (v !== 32'h0) begin failures++; $display("FAIL ctrl_strobe: got %h expected 0", v); end
      wr_raw((W-2)'(BASE + 1), 32'hFFFF_FFFF, 4'b0001);
      rd(1, v);
      checks++;
      if (v !== 32'h3) begin failures++; $display("FAIL ctrl_write: got %h expected 3", v); end
      rd_raw((W-2)'(BASE + 8 + 1), v);
      checks++;
      if (v !== 32'h0) begin failures++; $display("FAIL miss_read: got %h expected 0", v); end
   endtask

   task automatic test_tx();
      logic [31:0] v;
      wr(1, 32'h3);
      tx_push(32'hA1); tx_push(32'hB2); tx_push(32'hC3);
      rd(0, v);
      checks++;
      if (v !== 32'h0003_0000) begin failures++; $display("FAIL tx_status: got %h expected 00030000", v); end
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 32'hA1) begin
         failures++;
         $display("FAIL tx_head: valid=%b data=%h expected 1/a1", tx_valid, tx_data);
      end
      drain_tx("tx_stream");
   endtask

   task automatic test_tx_full();
      logic [31:0] v;
      wr(1, 32'h0);
      for (int i = 0; i < 9; i++) tx_push(32'h100 + i);
      rd(0, v);
      checks++;
      if (v !== 32'h0008_000A) begin failures++; $display("FAIL tx_full_status: got %h expected 0008000a", v); end
      checks++;
      if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_disabled: tx_valid=%b expected 0", tx_valid); end
      wr(5, 32'h8);
      rd(0, v);
      checks++;
      if (v !== 32'h0008_0002) begin failures++; $display("FAIL tx_drop_clear: got %h expected 00080002", v); end
      wr(1, 32'h2);
      drain_tx("tx_full_drain");
   endtask

   task automatic test_rx_overflow();
      logic [31:0] v;
      wr(1, 32'h1);
      for (int i = 0; i < 9; i++) rx_flit(32'h10 + i);
      rd(0, v);
      checks++;
      if (v !== 32'h0000_0805) begin failures++; $display("FAIL rx_ovf_status: got %h expected 00000805", v); end
      checks++;
      if (irq !== 1'b1) begin failures++; $display("FAIL rx_irq: irq=%b expected 1", irq); end
      rd(3, v);
      checks++;
      if (v !== rxq[0]) begin failures++; $display("FAIL rx_head0: got %h expected %h", v, rxq[0]); end
      wr(4, 32'h0);
      void'(rxq.pop_front());
      rd(3, v);
      checks++;
      if (v !== rxq[0]) begin failures++; $display("FAIL rx_head1: got %h expected %h", v, rxq[0]); end
      wr(5, 32'h4);
      rd(0, v);
      checks++;
      if (v !== 32'h0000_0701) begin failures++; $display("FAIL rx_ovf_clear: got %h expected 00000701", v); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      rx_flit(32'h20);  // refill to 8
      // pop and push together while full: both happen, no overflow
      addr_in = (W-2)'(BASE + 4); data_in = '0; wb_in = 4'hF;
      rx_valid = 1'b1; rx_data = 32'h99;
      tick();
      wb_in = 4'h0; rx_valid = 1'b0;
      void'(rxq.pop_front());
      rxq.push_back(32'h99);
      rd(0, v);
      checks++;
      if (v !== 32'h0000_0801) begin failures++; $display("FAIL rx_pop_push_full: got %h expected 00000801", v); end
      // overflow set in the same cycle as its clear: set wins
      addr_in = (W-2)'(BASE + 5); data_in = 32'h4; wb_in = 4'hF;
      rx_valid = 1'b1; rx_data = 32'h77;
      tick();
      wb_in = 4'h0; rx_valid = 1'b0;
      rd(0, v);
      checks++;
      if (v !== 32'h0000_0805) begin failures++; $display("FAIL set_wins: got %h expected 00000805", v); end
      wr(5, 32'h4);
      for (int i = 0; i < 10 && rxq.size() > 0; i++) begin
         rd(3, v);
         checks++;
         if (v !== rxq[0]) begin failures++; $display("FAIL rx_drain%0d: got %h expected %h", i, v, rxq[0]); end
         void'(rxq.pop_front());
         wr(4, 32'h0);
      end
      rd(0, v);
      checks++;
      if (v !== 32'h0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL rx_empty_end: status=%h irq=%b expected 0/0", v, irq);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      wr(1, 32'h1);
      tx_push(32'h55); tx_push(32'h66); tx_push(32'h77);
      rx_flit(32'h31); rx_flit(32'h32);
      wr(1, 32'h3);
      checks++;
      if (tx_valid !== 1'b1 || irq !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset: valid=%b irq=%b expected 1/1", tx_valid, irq);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (tx_valid !== 1'b0 || tx_data !== 32'h0 || irq !== 1'b0 || data_out !== 32'h0) begin
         failures++;
         $display("FAIL async_reset: valid=%b data=%h irq=%b dout=%h expected all 0", tx_valid, tx_data, irq, data_out);
      end
      txq.delete(); rxq.delete();
      tick();
      reset = 1'b1;
      rd(0, v);
      checks++;
      if (v !== 32'h0) begin failures++; $display("FAIL post_reset_status: got %h expected 0", v); end
      rd(1, v);
      checks++;
      if (v !== 32'h0) begin failures++; $display("FAIL post_reset_ctrl: got %h expected 0", v); end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_tx();
      test_tx_full();
      test_rx_overflow();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mmio_pkt_mailbox.md
# mmio_pkt_mailbox

Memory-mapped packet mailbox that sits on the MMIO side of the CPU/MMIO port, the responder opposite the CPU. It decodes CPU word addresses, byte strobes and write data into a small register file, and bridges the CPU to the packet network through a TX FIFO (CPU to network) and an RX FIFO (network to CPU). A registered read port and a level interrupt let the CPU poll or wait for incoming flits.

## Interface
- MEMORY_BUS_WIDTH, 32: data width. Word address width is MEMORY_BUS_WIDTH-2.
- FIFO_DEPTH, 8: entries per FIFO. Power of two, 2..128.
- BASE_WORD, 0: word address of register 0. Must be a multiple of 8.

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- addr_in  in  MEMORY_BUS_WIDTH-2  CPU word address
- data_in  in  MEMORY_BUS_WIDTH  CPU write data
- wb_in  in  4  byte write strobes. Nonzero means a write cycle.
- data_out  out  MEMORY_BUS_WIDTH  registered read data
- tx_data  out  MEMORY_BUS_WIDTH  TX FIFO head. 0 when empty.
- tx_valid  out  1  TX head available
- tx_ready  in  1  network accepts tx_data
- rx_data  in  MEMORY_BUS_WIDTH  incoming flit
- rx_valid  in  1  flit present this cycle. No backpressure.
- irq  out  1  level interrupt

## Operation
- Selection: `hit = (addr_in[MEMORY_BUS_WIDTH-3:3] == BASE_WORD>>3)`. `off = addr_in[2:0]`. Writes while not `hit` are ignored. Reads while not `hit` return 0.
- Register map (offset):
  - 0 STATUS, RO: bit0 rx_nonempty; bit1 tx_full; bit2 rx_overflow (sticky); bit3 tx_drop (sticky); [15:8] rx_count; [23:16] tx_count; other bits 0.
  - 1 CONTROL, RW: bit0 irq_en; bit1 tx_enable. Written only when wb_in[0]=1. Other bits read 0.
  - 2 TX_DATA, WO: a write with any strobe pushes the full data_in word. If the FIFO is full with no pop this cycle, the word is dropped and tx_drop is set.
  - 3 RX_DATA, RO: RX FIFO head. 0 when empty.
  - 4 RX_POP, WO: any write pops the RX FIFO if it is nonempty. When empty, the write has no effect.
  - 5 CLEAR, WO, write-1-to-clear: data_in[2] clears rx_overflow; data_in[3] clears tx_drop.
  - 6, 7: read 0, writes ignored.
- RX path: rx_valid=1 pushes rx_data.
  - If the FIFO is full and no RX_POP occurs this cycle, the flit is dropped and rx_overflow is set.
  - If RX_POP and rx_valid coincide while full, both occur and the flit is stored.
- TX path: tx_valid = tx_enable & tx_nonempty. A transfer happens when tx_valid & tx_ready; the head is popped at that edge.
  - A CPU push while full succeeds only if a transfer pops in the same cycle.
- Simultaneous push and pop on a nonempty FIFO: both occur and the count is unchanged.
- irq = irq_en & (rx_nonempty | rx_overflow), decoded from registered state.
- Counts are $clog2(FIFO_DEPTH)+1 bits, zero-extended into the 8-bit STATUS fields. Read and write pointers wrap modulo FIFO_DEPTH.
- A sticky-bit clear and a set in the same cycle: set wins.

## Timing
- Reset (asynchronous, active-low) clears all of the following:
  - outputs: data_out=0, tx_valid=0, tx_data=0, irq=0
  - control, sticky bits, pointers and counts
  - FIFO storage is not reset.
- Read latency is 1 cycle. data_out after edge N reflects addr_in sampled at edge N and the state before any write at edge N.
  - Back-to-back reads are allowed every cycle.
  - Reading RX_DATA in the same cycle as RX_POP returns the old head.
- Writes, pushes, pops and sticky updates take effect at the edge where they are sampled. STATUS reflects them from the next read.
- tx_data/tx_valid update 1 cycle after a push into an empty FIFO, with tx_enable=1.
- Back-to-back transfers at 1 flit/cycle when tx_ready is held high.
- Reset asserted mid-operation discards all FIFO contents immediately. No transfer completes in the reset cycle.

## Test plan
- Reset, then read offsets 0–7: all return 0; irq=0, tx_valid=0.
- Write CONTROL=0x3. Push 0xA1, 0xB2, 0xC3 to TX_DATA with tx_ready=0:
  - STATUS[23:16]=3; tx_data=0xA1.
  - Raise tx_ready: outputs 0xA1, 0xB2, 0xC3 on consecutive cycles, then tx_valid=0.
- With FIFO_DEPTH=8 and tx_enable=0, push 9 words:
  - STATUS reads tx_count=8, tx_full=1, tx_drop=1.
  - Writing CLEAR=0x8 clears tx_drop only.
- Drive 9 rx_valid flits 0x10..0x18 with irq_en=1:
  - rx_count=8, rx_overflow=1, irq=1.
  - RX_DATA reads 0x10. After RX_POP, it reads 0x11.
- RX full, RX_POP and rx_valid (0x99) in the same cycle:
  - count stays 8, no overflow, 0x99 is read last.
- Assert reset with both FIFOs partly full: counts return to 0 immediately, and STATUS reads 0 after release.
